// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-sharing controller: op codes, default widths, FSM states.
package alu_pkg;

  localparam int N_DEF = 2;
  localparam int M_DEF = 4;

  localparam logic [1:0] OP_SUB  = 2'b00;
  localparam logic [1:0] OP_COMP = 2'b01;
  localparam logic [1:0] OP_SUM  = 2'b10;
  localparam logic [1:0] OP_CONV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_rr_arbiter.sv
// 2-input request arbiter: round robin on rr, or fixed priority to requester 0 when
// ALU_SHARE_FIXED_PRIO_EN is defined. Purely combinational; grant is one-hot or zero.
module alu_rr_arbiter (
  input  logic [1:0] valid,
  input  logic       rr,
  input  logic       en,
  output logic [1:0] grant,
  output logic       idx
);

`ifdef ALU_SHARE_FIXED_PRIO_EN
  logic unused_rr;
  assign unused_rr = rr;

  always_comb begin
    grant = 2'b00;
    idx   = 1'b0;
    if (en) begin
      if (valid[0]) begin
        grant = 2'b01;
        idx   = 1'b0;
      end else if (valid[1]) begin
        grant = 2'b10;
        idx   = 1'b1;
      end
    end
  end
`else
  always_comb begin
    grant = 2'b00;
    idx   = 1'b0;
    if (en) begin
      if (valid[rr]) begin
        grant[rr] = 1'b1;
        idx       = rr;
      end else if (valid[~rr]) begin
        grant[~rr] = 1'b1;
        idx        = ~rr;
      end
    end
  end
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one registered-output ALU between two requesters; accept->response is 3 cycles.
// Optional macro ALU_SHARE_FIXED_PRIO_EN selects fixed priority instead of round robin.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic [1:0]     i_req_valid,
  output logic [1:0]     o_req_ready,
  input  logic [2*N-1:0] i_req_op,
  input  logic [2*M-1:0] i_req_arg_A,
  input  logic [2*M-1:0] i_req_arg_B,
  output logic [1:0]     o_rsp_valid,
  input  logic [1:0]     i_rsp_ready,
  output logic [M-1:0]   o_rsp_result,
  output logic [3:0]     o_rsp_status,
  output logic [N-1:0]   o_alu_op,
  output logic [M-1:0]   o_alu_arg_A,
  output logic [M-1:0]   o_alu_arg_B,
  input  logic [M-1:0]   i_alu_result,
  input  logic [3:0]     i_alu_status,
  output logic           o_busy
);

  state_t       state, state_nxt;
  logic [1:0]   grant;
  logic         gidx;
  logic         rr;
  logic         hold_g;
  logic [N-1:0] hold_op;
  logic [M-1:0] hold_a, hold_b;
  logic [M-1:0] rsp_result;
  logic [3:0]   rsp_status;
  logic         arb_en;
  logic         accept;
  logic         rsp_done;

  // Gating with the reset keeps ready low while reset is held, even though state is IDLE.
  assign arb_en   = (state == IDLE) && i_reset;
  assign accept   = |(i_req_valid & grant);
  assign rsp_done = (state == RESP) && i_rsp_ready[hold_g];

  alu_rr_arbiter u_arb (
    .valid (i_req_valid),
    .rr    (rr),
    .en    (arb_en),
    .grant (grant),
    .idx   (gidx)
  );

`ifdef ALU_SHARE_FIXED_PRIO_EN
  assign rr = 1'b0;
`else
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rr <= 1'b0;
    end else if (rsp_done) begin
      rr <= ~hold_g;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      hold_g  <= 1'b0;
      hold_op <= '0;
      hold_a  <= '0;
      hold_b  <= '0;
    end else if (accept) begin
      hold_g  <= gidx;
      hold_op <= gidx ? i_req_op[2*N-1:N]    : i_req_op[N-1:0];
      hold_a  <= gidx ? i_req_arg_A[2*M-1:M] : i_req_arg_A[M-1:0];
      hold_b  <= gidx ? i_req_arg_B[2*M-1:M] : i_req_arg_B[M-1:0];
    end
  end

  // The ALU registered its outputs at the end of ISSUE, so they are valid during WAIT.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rsp_result <= '0;
      rsp_status <= '0;
    end else if (state == WAIT) begin
      rsp_result <= i_alu_result;
      rsp_status <= i_alu_status;
    end
  end

  assign o_req_ready  = grant;
  assign o_rsp_valid  = (state == RESP) ? (hold_g ? 2'b10 : 2'b01) : 2'b00;
  assign o_rsp_result = rsp_result;
  assign o_rsp_status = rsp_status;
  assign o_alu_op     = hold_op;
  assign o_alu_arg_A  = hold_a;
  assign o_alu_arg_B  = hold_b;
  assign o_busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural registered ALU attached.
module tb_alu_share_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [3:0] rsp_result;
  logic [3:0] rsp_status;
  logic [1:0] alu_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_res;
  logic [3:0] alu_st;
  logic       busy;

  int checks = 0;
  int errors = 0;

  alu_share_ctrl dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_op     (req_op),
    .i_req_arg_A  (req_a),
    .i_req_arg_B  (req_b),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_result (rsp_result),
    .o_rsp_status (rsp_status),
    .o_alu_op     (alu_op),
    .o_alu_arg_A  (alu_a),
    .o_alu_arg_B  (alu_b),
    .i_alu_result (alu_res),
    .i_alu_status (alu_st),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: one-cycle registered result; status = {zero, sign, op}.
  function automatic logic [3:0] f_res(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] n;
    n = -a;
    case (op)
      2'b00:   return a - b;
      2'b01:   return (a < b) ? 4'd1 : 4'd0;
      2'b10:   return a + b;
      default: return a[3] ? {1'b1, n[2:0]} : a;
    endcase
  endfunction

  always @(posedge clk) begin
    alu_res <= f_res(alu_op, alu_a, alu_b);
    alu_st  <= {(f_res(alu_op, alu_a, alu_b) == 4'd0), f_res(alu_op, alu_a, alu_b)[3], alu_op};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       req;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic [3:0] st;
  } vec_t;

  vec_t vecs[7];

  task automatic set_req(input logic r, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    req_op[r*2 +: 2] = op;
    req_a[r*4 +: 4]  = a;
    req_b[r*4 +: 4]  = b;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    logic [1:0] oh;
    oh = v.req ? 2'b10 : 2'b01;
    @(posedge clk); #1;
    set_req(v.req, v.op, v.a, v.b);
    req_valid = oh;
    @(negedge clk);
    check($sformatf("v%0d_ready_T", k), req_ready, oh);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    check($sformatf("v%0d_alu_op", k), alu_op, v.op);
    check($sformatf("v%0d_alu_a", k), alu_a, v.a);
    check($sformatf("v%0d_busy_T1", k), busy, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    check($sformatf("v%0d_rsp_valid_T3", k), rsp_valid, oh);
    check($sformatf("v%0d_result", k), rsp_result, v.res);
    check($sformatf("v%0d_status", k), rsp_status, v.st);
    @(posedge clk); #1;
    @(negedge clk);
    check($sformatf("v%0d_idle_T4", k), {busy, rsp_valid}, 3'b000);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  int acc_cyc[4];
  int acc_g[4];
  int n_acc;
  int exp_g[4];
  int bad_rsp;

  initial begin
    vecs[0] = '{req: 1'b0, op: 2'b01, a: 4'd3,    b: 4'd5, res: 4'b0001, st: 4'b0001};
    vecs[1] = '{req: 1'b1, op: 2'b11, a: 4'b1011, b: 4'd0, res: 4'b1101, st: 4'b0111};
    vecs[2] = '{req: 1'b0, op: 2'b00, a: 4'd7,    b: 4'd2, res: 4'b0101, st: 4'b0000};
    vecs[3] = '{req: 1'b1, op: 2'b10, a: 4'd9,    b: 4'd7, res: 4'b0000, st: 4'b1010};
    vecs[4] = '{req: 1'b0, op: 2'b00, a: 4'd2,    b: 4'd5, res: 4'b1101, st: 4'b0100};
    vecs[5] = '{req: 1'b1, op: 2'b01, a: 4'd5,    b: 4'd3, res: 4'b0000, st: 4'b1001};
    vecs[6] = '{req: 1'b0, op: 2'b11, a: 4'b0110, b: 4'd0, res: 4'b0110, st: 4'b0011};
`ifdef ALU_SHARE_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif

    rst = 1'b0; req_valid = 2'b11; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {req_ready, rsp_valid, busy, rsp_result, rsp_status, alu_op, alu_a, alu_b}, 0);
    req_valid = 2'b00;
    rst = 1'b1;

    for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

    // Both requesters valid continuously from reset.
    do_reset();
    set_req(1'b0, 2'b10, 4'd1, 4'd1);
    set_req(1'b1, 2'b00, 4'd5, 4'd1);
    req_valid = 2'b11;
    n_acc = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00 && n_acc < 4) begin
        acc_cyc[n_acc] = c;
        acc_g[n_acc]   = req_ready[1] ? 1 : 0;
        n_acc++;
      end
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    check("rr_accept_count", n_acc, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_grant%0d", i), acc_g[i], exp_g[i]);
      check($sformatf("rr_cycle%0d", i), acc_cyc[i], 4 * i);
    end
    repeat (4) @(posedge clk);
    #1;

    // Response back-pressure for 5 cycles.
    do_reset();
    set_req(1'b0, 2'b10, 4'd3, 4'd4);
    req_valid = 2'b01;
    @(negedge clk);
    check("bp_ready_T", req_ready, 2'b01);
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    set_req(1'b1, 2'b00, 4'd1, 4'd1);
    req_valid = 2'b10;
    @(posedge clk); @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", i), {rsp_valid, rsp_result, rsp_status, req_ready, busy},
            {2'b01, 4'b0111, 4'b0010, 2'b00, 1'b1});
      @(posedge clk); #1;
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    check("bp_release_valid", rsp_valid, 2'b01);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_after_idle", {busy, rsp_valid, req_ready}, 5'b0_00_10);
    req_valid = 2'b00;
    rsp_ready = 2'b11;

    // Reset asserted while an operation sits in WAIT.
    do_reset();
    run_vec(vecs[0], 7);
    @(posedge clk); #1;
    set_req(1'b1, 2'b11, 4'b1011, 4'd0);
    req_valid = 2'b10;
    @(negedge clk);
    check("abort_ready_T", req_ready, 2'b10);
    @(posedge clk); #1;
    set_req(1'b0, 2'b10, 4'd2, 4'd2);
    req_valid = 2'b11;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_outputs_zero", {req_ready, rsp_valid, busy, rsp_result, rsp_status, alu_op, alu_a, alu_b}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_next_grant", req_ready, 2'b01);
    req_valid = 2'b00;
    bad_rsp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) bad_rsp++;
    end
    check("abort_no_response", bad_rsp, 0);
    check("abort_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Controller that shares one `sync_arith_unit_4` ALU between two requesters. It arbitrates incoming operation requests with a valid/ready handshake and sequences the selected operation through the ALU's one-cycle registered datapath. It captures result and status and returns them to the winning requester through a held valid/ready response channel. It sits between the requester front-ends and the ALU instance; the ALU itself is unchanged.

## Interface
- `N`, 2, operation code width (matches ALU `i_op`)
- `M`, 4, operand/result width (matches ALU `i_arg_A`/`i_arg_B`/`o_result`)
- `i_clk`  in  1  clock; all state updates on rising edge
- `i_reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `i_req_valid`  in  2  per-requester request valid; bit k = requester k
- `o_req_ready`  out  2  per-requester request accept
- `i_req_op`  in  2*N  packed ops; bits [k*N +: N] belong to requester k
- `i_req_arg_A`  in  2*M  packed operand A per requester
- `i_req_arg_B`  in  2*M  packed operand B per requester
- `o_rsp_valid`  out  2  per-requester response valid
- `i_rsp_ready`  in  2  per-requester response accept
- `o_rsp_result`  out  M  result; shared bus, valid for the requester whose `o_rsp_valid` bit is set
- `o_rsp_status`  out  4  status captured from the ALU
- `o_alu_op`  out  N  to ALU `i_op`
- `o_alu_arg_A`  out  M  to ALU `i_arg_A`
- `o_alu_arg_B`  out  M  to ALU `i_arg_B`
- `i_alu_result`  in  M  from ALU `o_result`
- `i_alu_status`  in  4  from ALU `o_status`
- `o_busy`  out  1  high in every state except IDLE

## Operation
- FSM states:
  - IDLE: accept a request and go to ISSUE.
  - ISSUE: go to WAIT unconditionally.
  - WAIT: capture result/status and go to RESP unconditionally.
  - RESP: on `o_rsp_valid[g] && i_rsp_ready[g]`, go to IDLE.
- Arbitration (IDLE only), 2-way round robin:
  - Pointer `rr` names the preferred requester.
  - Grant g = `rr` if `i_req_valid[rr]`, else the other requester if its valid is set; no grant if neither.
  - `o_req_ready[g]` = 1 combinationally in IDLE; every other ready bit is 0. Both ready bits are 0 outside IDLE.
- Accept: on handshake, register g, op, arg_A and arg_B into holding registers.
- `o_alu_*` are driven only from the holding registers. They are stable from ISSUE through RESP and keep their last value in IDLE.
- WAIT: latch `i_alu_result`/`i_alu_status` into response registers. The ALU registered its outputs at the end of ISSUE.
- RESP:
  - Only `o_rsp_valid[g]` is high.
  - Result and status are held until the handshake completes.
  - On completion, `rr` ← not g.
- Op codes are passed through untouched: SUB 00, COMP 01, SUM 10, CONV 11. No width changes; results are M bits exactly as the ALU produces them.
- Requests that are not granted must be held by the requester (valid stays high, payload stable). The controller never drops a valid request.
- Reset (asynchronous, any state, including mid-operation):
  - State → IDLE, `rr` → 0.
  - Every output register and holding register → 0.
  - `o_busy`, `o_rsp_valid` and `o_req_ready` read 0 while reset is asserted.
  - An operation in flight is discarded without a response.

## Timing
- Accept at cycle T (IDLE) → ISSUE at T+1 → WAIT at T+2 → RESP from T+3.
- `o_rsp_valid[g]` is first high at T+3.
- Minimum spacing between accepts is 4 cycles (T, T+4) when `i_rsp_ready` is already high.
- Back-pressure in RESP stalls the FSM. No new accept is possible until the handshake completes.
- Both valid in the same IDLE cycle: exactly one is granted, per `rr`.
- `o_busy` rises in the cycle after the accept.

## Configuration
- `ALU_SHARE_FIXED_PRIO_EN`:
  - Defined: fixed priority. Requester 0 always wins when valid, and `rr` is not implemented.
  - Undefined (default): round robin as described under Operation.

## Structure
- Shared package `alu_pkg`: ALU op-code localparams (SUB/COMP/SUM/CONV), default N/M, FSM state enum (IDLE, ISSUE, WAIT, RESP).
- One sub-module, `alu_rr_arbiter`: 2-input grant logic taking valid, `rr` and enable. It also contains the fixed-priority variant under the macro.

## Test plan
- Requester 0 alone, COMP, A=3, B=5:
  - `o_req_ready[0]`=1 at T.
  - `o_alu_op`=01 at T+1.
  - `o_rsp_valid[0]`=1 at T+3 with `o_rsp_result`=0001.
- Requester 1 alone, CONV, A=1011 → `o_rsp_valid[1]` at T+3 with result 1101, which is 1011 rewritten in sign-magnitude form (sign 1, magnitude 101). `o_rsp_valid[0]` stays 0.
- Both valid continuously from reset, `i_rsp_ready`=11:
  - Grant order is 0, 1, 0, 1.
  - Accepts at T, T+4, T+8.
  - With `ALU_SHARE_FIXED_PRIO_EN`, the order is 0, 0, 0.
- `i_rsp_ready`=0 for 5 cycles in RESP:
  - `o_rsp_valid`, result and status are held constant.
  - `o_req_ready`=00 and `o_busy`=1 throughout.
  - Handshake completes in the cycle `i_rsp_ready` rises; IDLE follows.
- Assert `i_reset`=0 during WAIT:
  - All outputs are 0 in the same cycle.
  - After release, no response is produced for the aborted op.
  - With both requesters valid, the next grant goes to requester 0.
